// File: rtl/tube_pkg.sv
/*----------------------------------------------------------------------
 * tube_pkg: shared types and constants for the tube display controller
 * Revision: 1.0
 *--------------------------------------------------------------------*/
`default_nettype none

package tube_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam int         MAX_DISP   = 9999;
  localparam int         DEF_BIN_W  = 14;

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more
  function automatic logic [15:0] dd_adjust(input logic [15:0] bcd);
    logic [15:0] res;
    res = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tube_scan_tick.sv
/*----------------------------------------------------------------------
 * tube_scan_tick: prescaler producing the digit driver's scan-enable pulse
 * Revision: 1.0
 *--------------------------------------------------------------------*/
`default_nettype none

module tube_scan_tick #(
  parameter int CLK_DIV = 50000
) (
  input  logic clk,
  input  logic rstn,
  input  logic disp_on,
  output logic en
);

  localparam int c_CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(CLK_DIV - 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               r_en;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
      r_en  <= 1'b0;
    end else if (!disp_on) begin
      r_cnt <= '0;
      r_en  <= 1'b0;
    end else begin
      r_en  <= (r_cnt == c_LAST);
      r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + c_CNT_W'(1);
    end
  end

  assign en = r_en;

endmodule

`default_nettype wire

// File: rtl/tube_display_ctrl.sv
/*----------------------------------------------------------------------
 * tube_display_ctrl: binary-to-BCD front end with blanking and scan tick
 * Revision: 1.0
 *--------------------------------------------------------------------*/
`default_nettype none

module tube_display_ctrl
  import tube_pkg::*;
#(
  parameter int BIN_W   = DEF_BIN_W,
  parameter int CLK_DIV = 50000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             disp_on,
  input  logic             val_valid,
  input  logic [BIN_W-1:0] val_data,
  input  logic             val_blank,
  output logic             val_ready,
  output logic             busy,
  output logic             ovf,
  output logic             en,
  output logic [3:0]       single_digit,
  output logic [3:0]       ten_digit,
  output logic [3:0]       hundred_digit,
  output logic [3:0]       kilo_digit
);

  localparam int c_CNT_W = $clog2(BIN_W + 1);
  localparam logic [c_CNT_W-1:0] c_LAST_ITER = c_CNT_W'(BIN_W - 1);

  state_t             r_state;
  logic [BIN_W-1:0]   r_bin;
  logic [15:0]        r_bcd;
  logic [c_CNT_W-1:0] r_iter;
  logic               r_blank;
  logic               r_ovf_pend;
  logic               r_ovf;
  logic [3:0]         r_kilo, r_hund, r_ten, r_unit;

  logic                w_sat;
  logic [BIN_W-1:0]    w_load;
  logic [15:0]         w_adj;
  logic [BIN_W+15:0]   w_shift;
  logic                w_bk_kilo, w_bk_hund, w_bk_ten;

  assign w_sat   = (32'(val_data) > 32'(MAX_DISP));
  assign w_load  = w_sat ? BIN_W'(MAX_DISP) : val_data;
  assign w_adj   = dd_adjust(r_bcd);
  assign w_shift = {w_adj, r_bin} << 1;

  // Leading-zero blanking cascades from the thousands digit down to tens
  assign w_bk_kilo = r_blank && (r_bcd[15:12] == 4'd0);
  assign w_bk_hund = w_bk_kilo && (r_bcd[11:8] == 4'd0);
  assign w_bk_ten  = w_bk_hund && (r_bcd[7:4] == 4'd0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_iter     <= '0;
      r_blank    <= 1'b0;
      r_ovf_pend <= 1'b0;
      r_ovf      <= 1'b0;
      r_kilo     <= 4'h0;
      r_hund     <= 4'h0;
      r_ten      <= 4'h0;
      r_unit     <= 4'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (val_valid) begin
            r_bin      <= w_load;
            r_ovf_pend <= w_sat;
            r_blank    <= val_blank;
            r_bcd      <= '0;
            r_iter     <= '0;
            r_state    <= ST_CONV;
          end
        end
        ST_CONV: begin
          {r_bcd, r_bin} <= w_shift;
          r_iter         <= r_iter + c_CNT_W'(1);
          if (r_iter == c_LAST_ITER) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_kilo  <= w_bk_kilo ? BLANK_CODE : r_bcd[15:12];
          r_hund  <= w_bk_hund ? BLANK_CODE : r_bcd[11:8];
          r_ten   <= w_bk_ten  ? BLANK_CODE : r_bcd[7:4];
          r_unit  <= r_bcd[3:0];
          r_ovf   <= r_ovf_pend;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign val_ready     = (r_state == ST_IDLE);
  assign busy          = (r_state != ST_IDLE);
  assign ovf           = r_ovf;
  assign kilo_digit    = r_kilo;
  assign hundred_digit = r_hund;
  assign ten_digit     = r_ten;
  assign single_digit  = r_unit;

  tube_scan_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_scan_tick (
    .clk    (clk),
    .rstn   (rstn),
    .disp_on(disp_on),
    .en     (en)
  );

endmodule

`default_nettype wire

// File: tb/tb_tube_display_ctrl.sv
/*----------------------------------------------------------------------
 * tb_tube_display_ctrl: directed vector bench for tube_display_ctrl
 * Revision: 1.0
 *--------------------------------------------------------------------*/
`default_nettype none

module tb_tube_display_ctrl;

  localparam int BIN_W   = 14;
  localparam int CLK_DIV = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic             disp_on;
  logic             val_valid;
  logic [BIN_W-1:0] val_data;
  logic             val_blank;
  logic             val_ready;
  logic             busy;
  logic             ovf;
  logic             en;
  logic [3:0]       single_digit, ten_digit, hundred_digit, kilo_digit;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] prev_digits;

  typedef struct {
    logic [BIN_W-1:0] data;
    logic             blank;
    logic [15:0]      digits;
    logic             ovf;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  tube_display_ctrl #(
    .BIN_W  (BIN_W),
    .CLK_DIV(CLK_DIV)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .disp_on      (disp_on),
    .val_valid    (val_valid),
    .val_data     (val_data),
    .val_blank    (val_blank),
    .val_ready    (val_ready),
    .busy         (busy),
    .ovf          (ovf),
    .en           (en),
    .single_digit (single_digit),
    .ten_digit    (ten_digit),
    .hundred_digit(hundred_digit),
    .kilo_digit   (kilo_digit)
  );

  function automatic logic [15:0] digits();
    return {kilo_digit, hundred_digit, ten_digit, single_digit};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!val_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "/ready_wait"}, 32'(val_ready), 32'd1);
  endtask

  // One full transfer: stable digits through T14, commit exactly at T15
  task automatic run_conv(input logic [BIN_W-1:0] d, input logic b,
                          input logic [15:0] exp_dig, input logic exp_ovf,
                          input string tag);
    wait_ready(tag);
    val_data  = d;
    val_blank = b;
    val_valid = 1'b1;
    @(posedge clk); #1;
    val_valid = 1'b0;
    check({tag, "/busy_T0"}, 32'(busy), 32'd1);
    repeat (BIN_W) @(posedge clk);
    #1;
    check({tag, "/stable_T14"}, 32'(digits()), 32'(prev_digits));
    check({tag, "/ready_T14"}, 32'(val_ready), 32'd0);
    @(posedge clk); #1;
    check({tag, "/digits"}, 32'(digits()), 32'(exp_dig));
    check({tag, "/ovf"}, 32'(ovf), 32'(exp_ovf));
    check({tag, "/ready_T15"}, 32'(val_ready), 32'd1);
    check({tag, "/busy_T15"}, 32'(busy), 32'd0);
    prev_digits = exp_dig;
  endtask

  initial begin
    vecs[0] = '{data: 14'd1234,  blank: 1'b0, digits: 16'h1234, ovf: 1'b0};
    vecs[1] = '{data: 14'd7,     blank: 1'b1, digits: 16'hFFF7, ovf: 1'b0};
    vecs[2] = '{data: 14'd0,     blank: 1'b1, digits: 16'hFFF0, ovf: 1'b0};
    vecs[3] = '{data: 14'd12000, blank: 1'b0, digits: 16'h9999, ovf: 1'b1};
    vecs[4] = '{data: 14'd50,    blank: 1'b0, digits: 16'h0050, ovf: 1'b0};
    vecs[5] = '{data: 14'd9999,  blank: 1'b0, digits: 16'h9999, ovf: 1'b0};
    vecs[6] = '{data: 14'd10000, blank: 1'b1, digits: 16'h9999, ovf: 1'b1};
    vecs[7] = '{data: 14'd305,   blank: 1'b1, digits: 16'hF305, ovf: 1'b0};
    vecs[8] = '{data: 14'd1000,  blank: 1'b1, digits: 16'h1000, ovf: 1'b0};
    vecs[9] = '{data: 14'd16383, blank: 1'b0, digits: 16'h9999, ovf: 1'b1};

    rstn      = 1'b0;
    disp_on   = 1'b0;
    val_valid = 1'b0;
    val_data  = '0;
    val_blank = 1'b0;
    prev_digits = 16'h0000;

    repeat (3) @(posedge clk);
    #1;
    check("reset/digits", 32'(digits()), 32'h0000);
    check("reset/ovf", 32'(ovf), 32'd0);
    check("reset/en", 32'(en), 32'd0);
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/ready", 32'(val_ready), 32'd1);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 10; i++)
      run_conv(vecs[i].data, vecs[i].blank, vecs[i].digits, vecs[i].ovf,
               $sformatf("vec%0d", i));

    // A request held through the conversion is only taken at T15+1
    wait_ready("held");
    val_data  = 14'd4321;
    val_blank = 1'b0;
    val_valid = 1'b1;
    @(posedge clk); #1;
    val_data = 14'd876;
    check("held/ready_T0", 32'(val_ready), 32'd0);
    repeat (BIN_W) @(posedge clk);
    #1;
    check("held/stable_T14", 32'(digits()), 32'(prev_digits));
    @(posedge clk); #1;
    check("held/first", 32'(digits()), 32'h4321);
    check("held/ready_T15", 32'(val_ready), 32'd1);
    @(posedge clk); #1;
    val_valid = 1'b0;
    check("held/busy_T0b", 32'(busy), 32'd1);
    repeat (BIN_W) @(posedge clk);
    #1;
    check("held/first_stable", 32'(digits()), 32'h4321);
    @(posedge clk); #1;
    check("held/second", 32'(digits()), 32'h0876);
    check("held/second_ovf", 32'(ovf), 32'd0);
    prev_digits = 16'h0876;

    // Asynchronous reset in the middle of a conversion
    run_conv(14'd15000, 1'b0, 16'h9999, 1'b1, "pre_rst");
    wait_ready("mid_rst");
    val_data  = 14'd5678;
    val_blank = 1'b0;
    val_valid = 1'b1;
    @(posedge clk); #1;
    val_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("mid_rst/digits", 32'(digits()), 32'h0000);
    check("mid_rst/busy", 32'(busy), 32'd0);
    check("mid_rst/ready", 32'(val_ready), 32'd1);
    check("mid_rst/ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    prev_digits = 16'h0000;
    run_conv(14'd42, 1'b0, 16'h0042, 1'b0, "post_rst");

    // Scan tick: pulse after every 4th edge while enabled
    disp_on = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      check($sformatf("tick/run%0d", k), 32'(en), 32'((k % 4) == 0));
    end
    disp_on = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("tick/off%0d", k), 32'(en), 32'd0);
    end
    disp_on = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("tick/rerun%0d", k), 32'(en), 32'(k == 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tube_display_ctrl.md
Name: tube_display_ctrl

Overview:
- Front-end controller for the 4-digit seven-segment scan driver.
- Accepts a binary value through a valid/ready handshake and converts it to BCD with an iterative double-dabble sequencer (one shift per cycle).
- Applies saturation and optional leading-zero blanking, then presents stable digit codes to the driver.
- Generates the driver's periodic scan-enable tick from a programmable prescaler.

Parameters:
- BIN_W, 14: width of the binary input value.
- CLK_DIV, 50000: scan tick period in clk cycles. Legal range is 2 or more.

Ports:
- clk  input  1  clock.
- rstn  input  1  asynchronous, active-low reset.
- disp_on  input  1  when 1, the scan tick runs; when 0, the tick is held off.
- val_valid  input  1  request to display val_data.
- val_data  input  BIN_W  unsigned binary value.
- val_blank  input  1  when 1, leading zeros are blanked; sampled together with val_data.
- val_ready  output  1  controller can accept a new value.
- busy  output  1  conversion in progress.
- ovf  output  1  last committed value was saturated.
- en  output  1  one-cycle scan-enable pulse to the digit driver.
- single_digit  output  4  units code to the driver.
- ten_digit  output  4  tens code to the driver.
- hundred_digit  output  4  hundreds code to the driver.
- kilo_digit  output  4  thousands code to the driver.

Behaviour:
- Reset values: all four digit outputs = 4'h0, ovf = 0, en = 0, busy = 0, val_ready = 1, FSM = IDLE, prescaler = 0, shift registers cleared.
- Reset is asynchronous and may arrive mid-conversion; the partial result is discarded.
- FSM states:
  - IDLE: val_ready = 1, busy = 0.
  - CONV: val_ready = 0, busy = 1.
  - DONE: val_ready = 0, busy = 1.
  - val_ready and busy are decoded from state only, with no combinational path from val_valid.
- Handshake: a transfer occurs on the rising edge where val_valid && val_ready (edge T0).
  - val_valid while not in IDLE is ignored.
  - The requester holds val_data until accepted.
- At T0:
  - If val_data > 9999, load 9999 and set ovf_pend = 1; otherwise load val_data and set ovf_pend = 0.
  - Capture val_blank.
  - Clear the 16-bit BCD accumulator and the iteration counter.
  - IDLE -> CONV.
- CONV, edges T1..T14 (BIN_W iterations):
  - For each BCD nibble >= 5, add 3.
  - Then shift {bcd, bin} left by 1.
  - The counter increments each edge; on the BIN_W-th shift, CONV -> DONE.
- DONE, edge T15:
  - Register the four nibbles into the digit outputs.
  - ovf <= ovf_pend.
  - DONE -> IDLE, so val_ready = 1 from T15 onward.
  - Fixed latency: the digits change exactly BIN_W+1 edges after acceptance.
  - The next value can be accepted at T15 + 1 at the earliest.
- Blanking (applied at commit when the captured blank flag = 1):
  - Replace each leading zero nibble, scanning from kilo downward, with BLANK_CODE = 4'hF.
  - Units is never blanked.
  - The digit driver decodes any non-BCD code as all segments off.
- Digit outputs change only at the DONE edge. Partial conversions are never visible.
- Scan tick:
  - The prescaler counts 0..CLK_DIV-1 and wraps.
  - en = 1 for exactly one cycle when the count equals CLK_DIV-1 and disp_on = 1.
  - When disp_on = 0, the prescaler is held at 0 and en = 0.
  - en is registered and independent of the conversion FSM.
- Width rules:
  - The BCD accumulator is 16 bits and never exceeds 9999 after saturation.
  - The iteration counter is clog2(BIN_W+1) bits.

Decomposition:
- Package tube_pkg holds:
  - FSM state encoding for IDLE/CONV/DONE.
  - BLANK_CODE = 4'hF.
  - MAX_DISP = 9999.
  - Default BIN_W.
- Sub-module tube_scan_tick implements the CLK_DIV prescaler and en pulse, with inputs clk, rstn, disp_on and output en. It is instantiated once.
- The conversion FSM and blanking logic stay in the top level.

Test Plan:
- val_data = 1234, val_blank = 0 -> at T15, kilo/hundred/ten/single = 1/2/3/4, ovf = 0, val_ready rises at T15.
- val_data = 7, val_blank = 1 -> digits F/F/F/7. val_data = 0, val_blank = 1 -> F/F/F/0.
- val_data = 12000 -> digits 9/9/9/9, ovf = 1. A following val_data = 50 -> 0/0/5/0, ovf = 0.
- Second val_valid held during CONV -> val_ready = 0 and the value is ignored. It is accepted at T15+1 and its digits commit 15 edges later; the first result is stable meanwhile.
- CLK_DIV = 4, disp_on = 1 -> en pulses every 4th cycle. Drop disp_on -> en = 0 next cycle. Re-raise -> first en pulse 4 cycles later.
- Assert rstn low at T7 of a conversion -> digits 0/0/0/0, busy = 0, val_ready = 1, ovf = 0. A new conversion after release completes normally.
